// File: rtl/mem_arbiter.sv
// mem_arbiter: shares one main-memory line port between the icache and the
// dcache. Round-robin on ties, with a lock that keeps a dirty-line write-back
// and its refill back to back. Every transaction is followed by one dead cycle.
module mem_arbiter #(
    parameter int ADDR_W = 28,
    parameter int LINE_W = 128
) (
    input  logic              clk_i,
    input  logic              rst_n_i,
    // icache miss interface
    input  logic              ic_read_i,
    input  logic [ADDR_W-1:0] ic_addr_i,
    output logic [LINE_W-1:0] ic_rdata_o,
    output logic              ic_ready_o,
    // dcache miss / write-back interface
    input  logic              dc_read_i,
    input  logic              dc_write_i,
    input  logic [ADDR_W-1:0] dc_addr_i,
    input  logic [LINE_W-1:0] dc_wdata_i,
    output logic [LINE_W-1:0] dc_rdata_o,
    output logic              dc_ready_o,
    // main-memory port
    output logic              mem_read_o,
    output logic              mem_write_o,
    output logic [ADDR_W-1:0] mem_addr_o,
    output logic [LINE_W-1:0] mem_wdata_o,
    input  logic [LINE_W-1:0] mem_rdata_i,
    input  logic              mem_ready_i,
    // debug: 00 idle, 01 icache, 10 dcache, 11 gap
    output logic [1:0]        grant_o
);

    // Encoding doubles as the debug grant value.
    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        GNT_I = 2'b01,
        GNT_D = 2'b10,
        GAP   = 2'b11
    } state_e;

    state_e state_q, state_d;
    logic   rr_last_q, rr_last_d;   // last owner: 0 = icache, 1 = dcache
    logic   lock_q, lock_d;         // refill after write-back pre-empts icache

    logic   ic_ready_d, dc_ready_d;
    logic   rd_d, wr_d;

    logic   ic_req, dc_req;
    assign ic_req = ic_read_i;
    assign dc_req = dc_read_i | dc_write_i;

    // State, round-robin pointer and lock registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_n_i) begin
            state_q   <= IDLE;
            rr_last_q <= 1'b0;
            lock_q    <= 1'b0;
        end else begin
            state_q   <= state_d;
            rr_last_q <= rr_last_d;
            lock_q    <= lock_d;
        end
    end

    // Next-state, arbitration and per-owner strobe / completion decode.
    always_comb begin
        state_d    = state_q;
        rr_last_d  = rr_last_q;
        lock_d     = lock_q;
        ic_ready_d = 1'b0;
        dc_ready_d = 1'b0;
        rd_d       = 1'b0;
        wr_d       = 1'b0;
        mem_addr_o = ic_addr_i;
        case (state_q)
            IDLE: begin
                // The lock lives for exactly one IDLE decision.
                lock_d = 1'b0;
                if (lock_q && dc_read_i) begin
                    state_d = GNT_D;
                end else if (ic_req && dc_req) begin
                    state_d = rr_last_q ? GNT_I : GNT_D;
                end else if (ic_req) begin
                    state_d = GNT_I;
                end else if (dc_req) begin
                    state_d = GNT_D;
                end
            end
            GNT_I: begin
                rd_d = 1'b1;
                if (mem_ready_i) begin
                    ic_ready_d = 1'b1;
                    rr_last_d  = 1'b0;
                    state_d    = GAP;
                end
            end
            GNT_D: begin
                mem_addr_o = dc_addr_i;
                // A simultaneous read+write performs only the write.
                rd_d       = dc_read_i & ~dc_write_i;
                wr_d       = dc_write_i;
                if (mem_ready_i) begin
                    dc_ready_d = 1'b1;
                    rr_last_d  = 1'b1;
                    lock_d     = dc_write_i;
                    state_d    = GAP;
                end
            end
            GAP: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // Outputs are forced low while reset is asserted so an in-flight
    // mem_ready cannot complete an abandoned transaction.
    assign mem_read_o  = rst_n_i & rd_d;
    assign mem_write_o = rst_n_i & wr_d;
    assign ic_ready_o  = rst_n_i & ic_ready_d;
    assign dc_ready_o  = rst_n_i & dc_ready_d;
    assign grant_o     = rst_n_i ? state_q : 2'b00;

    assign mem_wdata_o = dc_wdata_i;
    assign ic_rdata_o  = mem_rdata_i;
    assign dc_rdata_o  = mem_rdata_i;

endmodule

// File: tb/tb_mem_arbiter.sv
// Scoreboard bench for mem_arbiter: stimulus pushes expected completions,
// a monitor pops and compares on every ready pulse.
module tb_mem_arbiter;

    logic          clk;
    logic          rst_n;
    logic          ic_read;
    logic [27:0]   ic_addr;
    logic [127:0]  ic_rdata;
    logic          ic_ready;
    logic          dc_read;
    logic          dc_write;
    logic [27:0]   dc_addr;
    logic [127:0]  dc_wdata;
    logic [127:0]  dc_rdata;
    logic          dc_ready;
    logic          mem_read;
    logic          mem_write;
    logic [27:0]   mem_addr;
    logic [127:0]  mem_wdata;
    logic [127:0]  mem_rdata;
    logic          mem_ready;
    logic [1:0]    grant;

    mem_arbiter #(.ADDR_W(28), .LINE_W(128)) dut (
        .clk_i       (clk),
        .rst_n_i     (rst_n),
        .ic_read_i   (ic_read),
        .ic_addr_i   (ic_addr),
        .ic_rdata_o  (ic_rdata),
        .ic_ready_o  (ic_ready),
        .dc_read_i   (dc_read),
        .dc_write_i  (dc_write),
        .dc_addr_i   (dc_addr),
        .dc_wdata_i  (dc_wdata),
        .dc_rdata_o  (dc_rdata),
        .dc_ready_o  (dc_ready),
        .mem_read_o  (mem_read),
        .mem_write_o (mem_write),
        .mem_addr_o  (mem_addr),
        .mem_wdata_o (mem_wdata),
        .mem_rdata_i (mem_rdata),
        .mem_ready_i (mem_ready),
        .grant_o     (grant)
    );

    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    typedef struct {
        bit           is_dc;
        logic [27:0]  addr;
        bit           wr;
        logic [127:0] data;
    } exp_t;

    exp_t sb[$];
    int   passed = 0;
    int   total  = 0;
    int   lat    = 4;
    bit   mem_auto = 1'b1;

    localparam logic [127:0] W_WB   = 128'h01234567_89ABCDEF_FEDCBA98_76543210;
    localparam logic [127:0] W_BOTH = 128'h55555555_AAAAAAAA_55555555_AAAAAAAA;
    localparam logic [127:0] W_RST  = 128'h11112222_33334444_55556666_77778888;

    task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
        total++;
        if (act !== exp) begin
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end else begin
            passed++;
        end
    endtask

    function automatic logic [127:0] model_data(input logic [27:0] a);
        if (a == 28'h0000010) return {4{32'hDEADBEEF}};
        return {4{4'hC, a}};
    endfunction

    function automatic exp_t mk(input bit is_dc, input logic [27:0] addr,
                                input bit wr, input logic [127:0] data);
        exp_t e;
        e.is_dc = is_dc;
        e.addr  = addr;
        e.wr    = wr;
        e.data  = data;
        return e;
    endfunction

    // Memory responder: mem_ready pulses after the strobe has been high
    // for lat cycles, i.e. in the (lat+1)-th strobe cycle.
    initial begin : mem_model
        int cnt;
        cnt       = 0;
        mem_ready = 1'b0;
        mem_rdata = '0;
        forever begin
            @(posedge clk);
            #1;
            if (mem_auto) begin
                if (mem_ready) begin
                    mem_ready = 1'b0;
                    cnt = 0;
                end else if (mem_read || mem_write) begin
                    cnt++;
                    if (cnt > lat) begin
                        mem_ready = 1'b1;
                        mem_rdata = model_data(mem_addr);
                    end
                end else begin
                    cnt = 0;
                end
            end else begin
                cnt = 0;
            end
        end
    end

    // Monitor: every ready pulse consumes one scoreboard entry.
    initial begin : monitor
        exp_t e;
        forever begin
            @(negedge clk);
            if (ic_ready || dc_ready) begin
                chk("ready_exclusive", 128'(ic_ready & dc_ready), 128'd0);
                chk("sb_nonempty", 128'(sb.size() != 0), 128'd1);
                if (sb.size() != 0) begin
                    e = sb.pop_front();
                    chk("owner_is_dc", 128'(dc_ready), 128'(e.is_dc));
                    chk("mem_addr", 128'(mem_addr), 128'(e.addr));
                    chk("mem_write", 128'(mem_write), 128'(e.wr));
                    chk("mem_read", 128'(mem_read), 128'(!e.wr));
                    if (e.wr) chk("mem_wdata", mem_wdata, e.data);
                    else if (e.is_dc) chk("dc_rdata", dc_rdata, e.data);
                    else chk("ic_rdata", ic_rdata, e.data);
                end
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    // Waits for the next ready pulse, then returns in the following (GAP) cycle.
    task automatic wait_ready();
        int n;
        n = 0;
        do begin
            @(negedge clk);
            n++;
        end while (!(ic_ready || dc_ready) && n < 100);
        chk("ready_within_budget", 128'(n < 100), 128'd1);
        step();
    endtask

    initial begin : watchdog
        #1000000;
        $display("FAIL watchdog: got no finish expected finish");
        $fatal(1, "watchdog expired");
    end

    initial begin : stim
        int exp_g[8];
        logic [7:0] exp_rd;
        exp_g  = '{0, 1, 1, 1, 1, 1, 3, 0};
        exp_rd = 8'b0011_1110;

        rst_n = 1'b0; ic_read = 1'b0; ic_addr = '0;
        dc_read = 1'b0; dc_write = 1'b0; dc_addr = '0; dc_wdata = '0;
        repeat (3) @(posedge clk);
        @(negedge clk);
        chk("rst_mem_read", 128'(mem_read), 128'd0);
        chk("rst_mem_write", 128'(mem_write), 128'd0);
        chk("rst_ic_ready", 128'(ic_ready), 128'd0);
        chk("rst_dc_ready", 128'(dc_ready), 128'd0);
        chk("rst_grant", 128'(grant), 128'd0);
        step();
        rst_n = 1'b1;

        // Single icache fill, latency 4: strobe cycles 1-5, ready in cycle 5.
        lat = 4;
        ic_read = 1'b1;
        ic_addr = 28'h0000010;
        sb.push_back(mk(1'b0, 28'h0000010, 1'b0, {4{32'hDEADBEEF}}));
        for (int c = 0; c < 8; c++) begin
            @(negedge clk);
            chk($sformatf("t1_mem_read_c%0d", c), 128'(mem_read), 128'(exp_rd[c]));
            chk($sformatf("t1_grant_c%0d", c), 128'(grant), 128'(exp_g[c]));
            chk($sformatf("t1_ic_ready_c%0d", c), 128'(ic_ready), 128'(c == 5));
            step();
            if (c == 5) ic_read = 1'b0;
        end

        // Tie: dcache first, then icache; repeat and dcache wins again.
        lat = 2;
        for (int r = 0; r < 2; r++) begin
            ic_read = 1'b1; ic_addr = (r == 0) ? 28'h0000020 : 28'h0000040;
            dc_read = 1'b1; dc_addr = (r == 0) ? 28'h0000030 : 28'h0000050;
            if (r == 0) begin
                sb.push_back(mk(1'b1, 28'h0000030, 1'b0, 128'hC0000030_C0000030_C0000030_C0000030));
                sb.push_back(mk(1'b0, 28'h0000020, 1'b0, 128'hC0000020_C0000020_C0000020_C0000020));
            end else begin
                sb.push_back(mk(1'b1, 28'h0000050, 1'b0, 128'hC0000050_C0000050_C0000050_C0000050));
                sb.push_back(mk(1'b0, 28'h0000040, 1'b0, 128'hC0000040_C0000040_C0000040_C0000040));
            end
            wait_ready();
            dc_read = 1'b0;
            wait_ready();
            ic_read = 1'b0;
            step();
            step();
        end

        // Write-back then refill locked ahead of a waiting icache read.
        lat = 3;
        ic_read = 1'b1; ic_addr = 28'h0000060;
        dc_write = 1'b1; dc_addr = 28'h0000ABC; dc_wdata = W_WB;
        sb.push_back(mk(1'b1, 28'h0000ABC, 1'b1, W_WB));
        sb.push_back(mk(1'b1, 28'h0000DEF, 1'b0, 128'hC0000DEF_C0000DEF_C0000DEF_C0000DEF));
        sb.push_back(mk(1'b0, 28'h0000060, 1'b0, 128'hC0000060_C0000060_C0000060_C0000060));
        wait_ready();
        dc_write = 1'b0; dc_read = 1'b1; dc_addr = 28'h0000DEF;
        wait_ready();
        dc_read = 1'b0;
        wait_ready();
        ic_read = 1'b0;
        step();
        step();

        // Read and write together: write only, single pulse.
        lat = 1;
        dc_read = 1'b1; dc_write = 1'b1; dc_addr = 28'h0000077; dc_wdata = W_BOTH;
        sb.push_back(mk(1'b1, 28'h0000077, 1'b1, W_BOTH));
        @(negedge clk);
        chk("both_idle_grant", 128'(grant), 128'd0);
        step();
        @(negedge clk);
        chk("both_mem_read_low", 128'(mem_read), 128'd0);
        chk("both_mem_write_high", 128'(mem_write), 128'd1);
        wait_ready();
        dc_read = 1'b0; dc_write = 1'b0;
        repeat (3) step();

        // Reset during a dcache write with mem_ready pulsing inside reset.
        mem_auto = 1'b0;
        dc_write = 1'b1; dc_addr = 28'h0000099; dc_wdata = W_RST;
        step();
        @(negedge clk);
        chk("rst_txn_grant", 128'(grant), 128'd2);
        chk("rst_txn_mem_write", 128'(mem_write), 128'd1);
        step();
        rst_n = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("rst_mid_dc_ready", 128'(dc_ready), 128'd0);
        chk("rst_mid_mem_write", 128'(mem_write), 128'd0);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("rst_after_mem_write", 128'(mem_write), 128'd0);
        chk("rst_after_mem_read", 128'(mem_read), 128'd0);
        chk("rst_after_grant", 128'(grant), 128'd0);
        chk("rst_after_dc_ready", 128'(dc_ready), 128'd0);
        step();
        rst_n = 1'b1;
        lat = 2;
        sb.push_back(mk(1'b1, 28'h0000099, 1'b1, W_RST));
        mem_auto = 1'b1;
        @(negedge clk);
        chk("rearb_idle_grant", 128'(grant), 128'd0);
        step();
        @(negedge clk);
        chk("rearb_grant", 128'(grant), 128'd2);
        wait_ready();
        dc_write = 1'b0;
        repeat (3) step();

        // Spurious mem_ready while idle.
        mem_auto = 1'b0;
        mem_ready = 1'b1;
        @(negedge clk);
        chk("spur_ic_ready", 128'(ic_ready), 128'd0);
        chk("spur_dc_ready", 128'(dc_ready), 128'd0);
        chk("spur_grant", 128'(grant), 128'd0);
        step();
        mem_ready = 1'b0;
        @(negedge clk);
        chk("spur_after_grant", 128'(grant), 128'd0);
        chk("spur_after_mem_read", 128'(mem_read), 128'd0);
        mem_auto = 1'b1;
        step();
        ic_read = 1'b1; ic_addr = 28'h0000123;
        sb.push_back(mk(1'b0, 28'h0000123, 1'b0, 128'hC0000123_C0000123_C0000123_C0000123));
        wait_ready();
        ic_read = 1'b0;
        repeat (3) step();

        chk("sb_drained", 128'(sb.size()), 128'd0);
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
